// File: rtl/rvvi_retire_buffer_if.sv
// Retire-buffer bus: raw RVVI retirement in, compressed record stream and sticky status out.
// master = trace driver / sampler side, slave = rvvi_retire_buffer.
interface rvvi_retire_buffer_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic                 in_valid;
  logic [63:0]          in_order;
  logic [31:0]          in_insn;
  logic [XLEN-1:0]      in_pc;
  logic                 in_trap;
  logic [1:0]           in_mode;
  logic [31:0]          in_x_wb;
  logic [32*XLEN-1:0]   in_x_wdata;

  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_order;
  logic [31:0]          out_insn;
  logic [XLEN-1:0]      out_pc;
  logic                 out_trap;
  logic [1:0]           out_mode;
  logic [4:0]           out_rd;
  logic [XLEN-1:0]      out_rd_data;

  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic                 multi_wb;
  logic                 order_err;

  modport master (
    output in_valid, in_order, in_insn, in_pc, in_trap, in_mode, in_x_wb, in_x_wdata,
    output out_ready,
    input  out_valid, out_order, out_insn, out_pc, out_trap, out_mode, out_rd, out_rd_data,
    input  count, overflow, multi_wb, order_err
  );

  modport slave (
    input  in_valid, in_order, in_insn, in_pc, in_trap, in_mode, in_x_wb, in_x_wdata,
    input  out_ready,
    output out_valid, out_order, out_insn, out_pc, out_trap, out_mode, out_rd, out_rd_data,
    output count, overflow, multi_wb, order_err
  );
endinterface

// File: rtl/rvvi_retire_buffer.sv
// Compresses RVVI retirements to (rd, data) records in a FIFO; 1-cycle min latency, drops + flags overflow when full.
// Optional retirement-order checking is compiled in with RVVI_ORDER_CHECK_EN.
module rvvi_retire_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rvvi_retire_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic            trap;
    logic [1:0]      mode;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             in_rec;
  rec_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             multi_wb_q;
  logic [31:0]      wb_hi;
  logic [4:0]       rd_idx;
  logic [XLEN-1:0]  rd_val;
  logic             wb_multi;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // x0 writes are architecturally invisible, so bit 0 never selects rd.
  always_comb begin
    wb_hi  = bus.in_x_wb & ~32'd1;
    rd_idx = '0;
    rd_val = '0;
    for (int i = 31; i >= 1; i--) begin
      if (wb_hi[i]) begin
        rd_idx = 5'(i);
        rd_val = bus.in_x_wdata[i*XLEN +: XLEN];
      end
    end
    wb_multi = |(wb_hi & (wb_hi - 32'd1));
  end

  always_comb begin
    in_rec         = '0;
    in_rec.order   = bus.in_order;
    in_rec.insn    = bus.in_insn;
    in_rec.pc      = bus.in_pc;
    in_rec.trap    = bus.in_trap;
    in_rec.mode    = bus.in_mode;
    in_rec.rd      = rd_idx;
    in_rec.rd_data = rd_val;
  end

  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = (count_q != '0) && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_rec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      multi_wb_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
      if (bus.in_valid && wb_multi) multi_wb_q <= 1'b1;
    end
  end

  // Storage is not reset; masking the head keeps outputs zero while empty.
  assign head = (count_q != '0) ? mem[rd_ptr] : '0;

  assign bus.out_valid   = (count_q != '0);
  assign bus.out_order   = head.order;
  assign bus.out_insn    = head.insn;
  assign bus.out_pc      = head.pc;
  assign bus.out_trap    = head.trap;
  assign bus.out_mode    = head.mode;
  assign bus.out_rd      = head.rd;
  assign bus.out_rd_data = head.rd_data;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.multi_wb    = multi_wb_q;

`ifdef RVVI_ORDER_CHECK_EN
  logic [63:0] expected_q;
  logic        first_seen_q;
  logic        order_err_q;

  // Reloading from the observed order keeps one gap from cascading into repeated errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expected_q   <= 64'd1;
      first_seen_q <= 1'b0;
      order_err_q  <= 1'b0;
    end else if (bus.in_valid) begin
      if (first_seen_q && (bus.in_order != expected_q)) order_err_q <= 1'b1;
      expected_q   <= bus.in_order + 64'd1;
      first_seen_q <= 1'b1;
    end
  end

  assign bus.order_err = order_err_q;
`else
  assign bus.order_err = 1'b0;
`endif

endmodule
